// File: rtl/axi_rdata_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_rdata_arb_pkg
// Description : Shared definitions for the AXI read-data arbiter: arbiter
//               state encoding, default parameter widths and a small helper
//               for sizing source-index fields.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_rdata_arb_pkg;

    // Default widths used by the arbiter and its sub-module
    localparam int DEF_NUM_SRC   = 2;
    localparam int DEF_ID_WID    = 8;
    localparam int DEF_DATA_WID  = 32;
    localparam int DEF_USER_WID  = 2;
    localparam int DEF_MAX_BEATS = 256;

    // Arbiter state encoding
    localparam logic ST_IDLE_ENC = 1'b0;
    localparam logic ST_BUSY_ENC = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE_ENC,
        BUSY = ST_BUSY_ENC
    } arb_state_t;

    // Width of a source index; a single source still needs one bit
    function automatic int idx_width(input int num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

endpackage : axi_rdata_arb_pkg
`default_nettype wire

// File: rtl/axi_rdata_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : axi_rdata_arb_rr_pick  (rr_pick)
// Description : Combinational round-robin first-set finder. Starting at ptr
//               and searching upward modulo NUM_SRC, returns the first set
//               bit of req as a one-hot vector and as a binary index.
// Revision    : 1.0 - initial release
// Ports       :
//   req        [NUM_SRC-1:0]  request vector
//   ptr        [IDX_W-1:0]    search start position (0..NUM_SRC-1)
//   gnt_onehot [NUM_SRC-1:0]  one-hot winner, zero when req is zero
//   gnt_idx    [IDX_W-1:0]    binary winner index, zero when req is zero
// ============================================================================
module axi_rdata_arb_rr_pick
    import axi_rdata_arb_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    localparam int IDX_W  = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx
);

    always_comb begin : p_pick
        logic             found;
        int               cand;
        logic [IDX_W-1:0] cand_idx;

        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        // Visit positions ptr, ptr+1, ... wrapping once past NUM_SRC-1
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found                = 1'b1;
                gnt_onehot[cand_idx] = 1'b1;
                gnt_idx              = cand_idx;
            end
        end
    end

endmodule : axi_rdata_arb_rr_pick
`default_nettype wire

// File: rtl/axi_rdata_arb.sv
`default_nettype none
// ============================================================================
// Module      : axi_rdata_arb
// Description : Burst-atomic round-robin arbiter merging NUM_SRC memory-side
//               AXI R channels onto one registered application-side R
//               channel. An IDLE cycle separates every burst; a burst that
//               reaches MAX_BEATS without RLAST is cut off and flagged in the
//               sticky out_err.
// Revision    : 1.0 - initial release
// Ports       :
//   clk          block clock, rising edge
//   reset_       asynchronous active-low reset
//   in_rid/in_rdata/in_rresp/in_ruser/in_rlast   packed per-source R fields
//   in_mrvalid   per-source beat valid
//   out_mrready  per-source ready (only the owner may see ready)
//   out_rid/out_rdata/out_rresp/out_ruser/out_rlast   registered output beat
//   out_srvalid  registered output valid
//   in_srready   output-side ready
//   out_grant    registered one-hot owner, zero when idle
//   out_err      sticky burst-overrun flag
// ============================================================================
module axi_rdata_arb
    import axi_rdata_arb_pkg::*;
#(
    parameter int NUM_SRC   = DEF_NUM_SRC,
    parameter int ID_WID    = DEF_ID_WID,
    parameter int DATA_WID  = DEF_DATA_WID,
    parameter int USER_WID  = DEF_USER_WID,
    parameter int MAX_BEATS = DEF_MAX_BEATS
) (
    input  logic                         clk,
    input  logic                         reset_,
    input  logic [NUM_SRC*ID_WID-1:0]    in_rid,
    input  logic [NUM_SRC*DATA_WID-1:0]  in_rdata,
    input  logic [NUM_SRC*2-1:0]         in_rresp,
    input  logic [NUM_SRC*USER_WID-1:0]  in_ruser,
    input  logic [NUM_SRC-1:0]           in_rlast,
    input  logic [NUM_SRC-1:0]           in_mrvalid,
    output logic [NUM_SRC-1:0]           out_mrready,
    output logic [ID_WID-1:0]            out_rid,
    output logic [DATA_WID-1:0]          out_rdata,
    output logic [1:0]                   out_rresp,
    output logic [USER_WID-1:0]          out_ruser,
    output logic                         out_rlast,
    output logic                         out_srvalid,
    input  logic                         in_srready,
    output logic [NUM_SRC-1:0]           out_grant,
    output logic                         out_err
);

    localparam int IDX_W = idx_width(NUM_SRC);
    localparam int CNT_W = $clog2(MAX_BEATS) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SRC - 1);
    // Count value held while the MAX_BEATS-th beat is being accepted
    localparam logic [CNT_W-1:0] FINAL_CNT = CNT_W'(MAX_BEATS - 1);

    arb_state_t          state;
    logic [IDX_W-1:0]    owner;
    logic [IDX_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]    beat_cnt;

    logic [NUM_SRC-1:0]  pick_onehot;
    logic [IDX_W-1:0]    pick_idx;

    logic                out_free;
    logic                accept;
    logic                at_limit;
    logic                burst_end;
    logic                overrun;
    logic [IDX_W-1:0]    next_ptr;

    logic [ID_WID-1:0]   sel_rid;
    logic [DATA_WID-1:0] sel_rdata;
    logic [1:0]          sel_rresp;
    logic [USER_WID-1:0] sel_ruser;
    logic                sel_rlast;

    // ------------------------------------------------------------------
    // Round-robin selection of the next owner
    // ------------------------------------------------------------------
    axi_rdata_arb_rr_pick #(
        .NUM_SRC    (NUM_SRC)
    ) u_rr_pick (
        .req        (in_mrvalid),
        .ptr        (rr_ptr),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx)
    );

    // ------------------------------------------------------------------
    // Owner's beat fields
    // ------------------------------------------------------------------
    assign sel_rid   = in_rid  [owner*ID_WID   +: ID_WID];
    assign sel_rdata = in_rdata[owner*DATA_WID +: DATA_WID];
    assign sel_rresp = in_rresp[owner*2        +: 2];
    assign sel_ruser = in_ruser[owner*USER_WID +: USER_WID];
    assign sel_rlast = in_rlast[owner];

    // The output register can take a beat when empty or draining this cycle.
    // out_grant is the registered one-hot owner, so it doubles as the ready
    // mask; it is already zero in IDLE, the state test just makes the bubble
    // explicit.
    assign out_free    = ~out_srvalid | in_srready;
    assign out_mrready = ((state == BUSY) && out_free) ? out_grant : '0;
    assign accept      = |(in_mrvalid & out_mrready);

    assign at_limit  = (beat_cnt == FINAL_CNT);
    assign burst_end = sel_rlast | at_limit;
    assign overrun   = at_limit & ~sel_rlast;
    assign next_ptr  = (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);

    // ------------------------------------------------------------------
    // Arbiter FSM with registered output beat, grant and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            beat_cnt    <= '0;
            out_grant   <= '0;
            out_err     <= 1'b0;
            out_srvalid <= 1'b0;
            out_rid     <= '0;
            out_rdata   <= '0;
            out_rresp   <= '0;
            out_ruser   <= '0;
            out_rlast   <= 1'b0;
        end else begin
            // Output register: a new beat wins over draining the old one;
            // on a plain drain only valid/last drop, data fields hold.
            if (accept) begin
                out_srvalid <= 1'b1;
                out_rid     <= sel_rid;
                out_rdata   <= sel_rdata;
                out_rresp   <= sel_rresp;
                out_ruser   <= sel_ruser;
                out_rlast   <= sel_rlast;
            end else if (out_srvalid && in_srready) begin
                out_srvalid <= 1'b0;
                out_rlast   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (|in_mrvalid) begin
                        state     <= BUSY;
                        owner     <= pick_idx;
                        out_grant <= pick_onehot;
                        beat_cnt  <= '0;
                    end
                end
                BUSY: begin
                    // Ownership only ends on an accepted beat; a source that
                    // drops valid mid-burst keeps the grant.
                    if (accept) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (burst_end) begin
                            state     <= IDLE;
                            out_grant <= '0;
                            rr_ptr    <= next_ptr;
                            if (overrun) begin
                                out_err <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : axi_rdata_arb
`default_nettype wire

// File: tb/tb_axi_rdata_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rdata_arb
// Description : Self-checking bench for axi_rdata_arb. Sources are queues of
//               beats; a burst-level round-robin model predicts the output
//               beat stream, grant order and error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rdata_arb;

    localparam int N  = 3;
    localparam int IW = 4;
    localparam int DW = 16;
    localparam int UW = 2;
    localparam int MB = 4;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic            clk;
    logic            reset_;
    logic [N*IW-1:0] in_rid;
    logic [N*DW-1:0] in_rdata;
    logic [N*2-1:0]  in_rresp;
    logic [N*UW-1:0] in_ruser;
    logic [N-1:0]    in_rlast;
    logic [N-1:0]    in_mrvalid;
    logic [N-1:0]    out_mrready;
    logic [IW-1:0]   out_rid;
    logic [DW-1:0]   out_rdata;
    logic [1:0]      out_rresp;
    logic [UW-1:0]   out_ruser;
    logic            out_rlast;
    logic            out_srvalid;
    logic            in_srready;
    logic [N-1:0]    out_grant;
    logic            out_err;

    axi_rdata_arb #(
        .NUM_SRC   (N),
        .ID_WID    (IW),
        .DATA_WID  (DW),
        .USER_WID  (UW),
        .MAX_BEATS (MB)
    ) dut (
        .clk         (clk),
        .reset_      (reset_),
        .in_rid      (in_rid),
        .in_rdata    (in_rdata),
        .in_rresp    (in_rresp),
        .in_ruser    (in_ruser),
        .in_rlast    (in_rlast),
        .in_mrvalid  (in_mrvalid),
        .out_mrready (out_mrready),
        .out_rid     (out_rid),
        .out_rdata   (out_rdata),
        .out_rresp   (out_rresp),
        .out_ruser   (out_ruser),
        .out_rlast   (out_rlast),
        .out_srvalid (out_srvalid),
        .in_srready  (in_srready),
        .out_grant   (out_grant),
        .out_err     (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench state
    beat_t        srcq [N][$];
    beat_t        obs[$];
    beat_t        expq[$];
    int           grant_log[$];
    int           exp_grants[$];
    bit           exp_err;
    logic [N-1:0] hs;
    int           gap_pct;
    int           stall_pct;
    bit           ready_rand;
    logic         ready_force;
    int           n_cmp;
    int           n_fail;
    int           stall_viol;
    int           no_gap_cnt;
    int           bad_grant;
    int           bad_ready;
    logic [N-1:0] prev_grant;
    bit           hold_pending;
    beat_t        held;
    int           tag_ctr;

    // Source driver: pops a beat after each handshake seen on the previous
    // falling edge and presents the next one. Only the current owner may
    // randomly withhold valid, so every pending source requests in IDLE.
    initial begin
        beat_t        b;
        logic [N*IW-1:0] rid;
        logic [N*DW-1:0] rdata;
        logic [N*2-1:0]  rresp;
        logic [N*UW-1:0] ruser;
        logic [N-1:0]    rlast;
        logic [N-1:0]    vld;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            end
            hs = '0;
            rid = '0; rdata = '0; rresp = '0; ruser = '0; rlast = '0; vld = '0;
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() > 0) begin
                    b = srcq[i][0];
                    vld[i] = (out_grant[i] == 1'b0) || ($urandom_range(99) >= gap_pct);
                    rid[i*IW +: IW]   = b.id;
                    rdata[i*DW +: DW] = b.data;
                    rresp[i*2 +: 2]   = b.resp;
                    ruser[i*UW +: UW] = b.user;
                    rlast[i]          = b.last;
                end
            end
            in_mrvalid = vld; in_rid = rid; in_rdata = rdata;
            in_rresp = rresp; in_ruser = ruser; in_rlast = rlast;
            in_srready = ready_rand ? ($urandom_range(99) >= stall_pct) : ready_force;
        end
    end

    // Monitor: records output handshakes and grant transitions, and tallies
    // protocol violations for the tests to inspect.
    initial begin
        beat_t        cur;
        logic [N-1:0] exp_rdy;
        forever begin
            @(negedge clk);
            if (reset_) begin
                hs = in_mrvalid & out_mrready;
                cur.id = out_rid; cur.data = out_rdata; cur.resp = out_rresp;
                cur.user = out_ruser; cur.last = out_rlast;
                if (hold_pending && (!out_srvalid || cur !== held)) stall_viol++;
                hold_pending = out_srvalid && !in_srready;
                held = cur;
                if (out_srvalid && in_srready) obs.push_back(cur);
                if (out_grant != prev_grant) begin
                    if (out_grant != '0) begin
                        if (prev_grant != '0) no_gap_cnt++;
                        for (int i = 0; i < N; i++) if (out_grant[i]) grant_log.push_back(i);
                    end
                    prev_grant = out_grant;
                end
                if (!$onehot0(out_grant)) bad_grant++;
                exp_rdy = (out_grant != '0 && (!out_srvalid || in_srready)) ? out_grant : '0;
                if (out_mrready !== exp_rdy) bad_ready++;
            end else begin
                hs = '0;
                hold_pending = 1'b0;
                prev_grant = '0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic reset_clear();
        for (int i = 0; i < N; i++) srcq[i].delete();
        obs.delete(); expq.delete(); grant_log.delete(); exp_grants.delete();
        hs = '0; gap_pct = 0; stall_pct = 0; ready_rand = 0; ready_force = 1'b1;
        stall_viol = 0; no_gap_cnt = 0; bad_grant = 0; bad_ready = 0;
        exp_err = 0;
    endtask

    task automatic do_reset();
        reset_ = 1'b0;
        reset_clear();
        repeat (3) @(negedge clk);
        #1;
        reset_ = 1'b1;
    endtask

    task automatic push_burst(input int s, input int len, input bit with_last);
        beat_t b;
        tag_ctr++;
        for (int k = 0; k < len; k++) begin
            b.id   = IW'(s);
            b.data = {4'(s), 8'(tag_ctr), 4'(k)};
            b.resp = 2'($urandom_range(3));
            b.user = UW'($urandom_range(3));
            b.last = with_last && (k == len - 1);
            srcq[s].push_back(b);
        end
    endtask

    // Burst-level reference: every source with pending beats requests when
    // the arbiter is idle; the owner keeps the channel until RLAST or MB
    // beats, then the search restarts just after it.
    task automatic build_model();
        beat_t mq [N][$];
        beat_t b;
        int    ptr, src, taken, s;
        bit    found;
        expq.delete(); exp_grants.delete(); exp_err = 0;
        for (int i = 0; i < N; i++) mq[i] = srcq[i];
        ptr = 0;
        while (1) begin
            found = 0; src = 0;
            for (int k = 0; k < N; k++) begin
                s = (ptr + k) % N;
                if (!found && mq[s].size() > 0) begin found = 1; src = s; end
            end
            if (!found) break;
            exp_grants.push_back(src);
            taken = 0;
            while (mq[src].size() > 0) begin
                b = mq[src].pop_front();
                expq.push_back(b);
                taken++;
                if (b.last) break;
                if (taken == MB) begin exp_err = 1; break; end
            end
            ptr = (src + 1) % N;
        end
    endtask

    task automatic wait_obs(input int n, input int budget);
        for (int c = 0; c < budget && obs.size() < n; c++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++; if (out_grant !== '0)   begin n_fail++; $display("FAIL reset_grant: got %b want 0", out_grant); end
        n_cmp++; if (out_err !== 1'b0)   begin n_fail++; $display("FAIL reset_err: got %b want 0", out_err); end
        n_cmp++; if (out_srvalid !== 1'b0) begin n_fail++; $display("FAIL reset_srvalid: got %b want 0", out_srvalid); end
        n_cmp++; if (out_rlast !== 1'b0) begin n_fail++; $display("FAIL reset_rlast: got %b want 0", out_rlast); end
        n_cmp++; if (out_rdata !== '0)   begin n_fail++; $display("FAIL reset_rdata: got %h want 0", out_rdata); end
        n_cmp++; if (out_rid !== '0)     begin n_fail++; $display("FAIL reset_rid: got %h want 0", out_rid); end
        n_cmp++; if (out_rresp !== '0)   begin n_fail++; $display("FAIL reset_rresp: got %h want 0", out_rresp); end
        n_cmp++; if (out_ruser !== '0)   begin n_fail++; $display("FAIL reset_ruser: got %h want 0", out_ruser); end
        n_cmp++; if (out_mrready !== '0) begin n_fail++; $display("FAIL reset_mrready: got %b want 0", out_mrready); end
    endtask

    task automatic test_single_burst();
        beat_t b;
        do_reset();
        @(negedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            b.id = 4'h5; b.data = DW'(16'h10 + k); b.resp = 2'b00; b.user = 2'b01;
            b.last = (k == 3);
            srcq[0].push_back(b);
        end
        repeat (2) @(negedge clk);
        n_cmp++; if (out_grant !== 3'b001) begin n_fail++; $display("FAIL single_grant: got %b want 001", out_grant); end
        n_cmp++; if (out_srvalid !== 1'b0) begin n_fail++; $display("FAIL single_bubble: got %b want 0", out_srvalid); end
        n_cmp++; if (out_mrready !== 3'b001) begin n_fail++; $display("FAIL single_mrready: got %b want 001", out_mrready); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_srvalid !== 1'b1 || out_rdata !== DW'(16'h10 + k) || out_rlast !== (k == 3)) begin
                n_fail++;
                $display("FAIL single_beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         k, out_srvalid, out_rdata, out_rlast, 16'h10 + k, (k == 3));
            end
        end
        n_cmp++; if (out_grant !== '0) begin n_fail++; $display("FAIL single_release: got %b want 000", out_grant); end
        @(negedge clk);
        n_cmp++; if (out_srvalid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", out_srvalid); end
    endtask

    task automatic test_alternate();
        do_reset();
        @(negedge clk); #1;
        for (int j = 0; j < 3; j++) begin
            push_burst(0, 2, 1);
            push_burst(1, 2, 1);
        end
        build_model();
        wait_obs(expq.size(), 400);
        n_cmp++; if (obs.size() !== expq.size()) begin n_fail++; $display("FAIL alt_count: got %0d want %0d", obs.size(), expq.size()); end
        for (int k = 0; k < expq.size() && k < obs.size(); k++) begin
            n_cmp++; if (obs[k] !== expq[k]) begin n_fail++; $display("FAIL alt_beat%0d: got %h want %h", k, obs[k], expq[k]); end
        end
        n_cmp++; if (grant_log.size() !== 6) begin n_fail++; $display("FAIL alt_ngrants: got %0d want 6", grant_log.size()); end
        for (int k = 0; k < grant_log.size() && k < 6; k++) begin
            n_cmp++; if (grant_log[k] !== k % 2) begin n_fail++; $display("FAIL alt_order%0d: got %0d want %0d", k, grant_log[k], k % 2); end
        end
        n_cmp++; if (no_gap_cnt !== 0) begin n_fail++; $display("FAIL alt_gap: got %0d direct handovers want 0", no_gap_cnt); end
    endtask

    task automatic test_backpressure();
        beat_t e[$];
        do_reset();
        @(negedge clk); #1;
        ready_force = 1'b0;
        push_burst(1, 3, 1);
        e = srcq[1];
        repeat (3) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (out_srvalid !== 1'b1 || out_rdata !== e[0].data || out_mrready !== 3'b000) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b d=%h rdy=%b want v=1 d=%h rdy=000",
                         c, out_srvalid, out_rdata, out_mrready, e[0].data);
            end
            if (c < 4) @(negedge clk);
        end
        #1;
        ready_force = 1'b1;
        wait_obs(3, 100);
        n_cmp++; if (obs.size() !== 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", obs.size()); end
        for (int k = 0; k < 3 && k < obs.size(); k++) begin
            n_cmp++; if (obs[k] !== e[k]) begin n_fail++; $display("FAIL bp_beat%0d: got %h want %h", k, obs[k], e[k]); end
        end
        n_cmp++; if (stall_viol !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes want 0", stall_viol); end
    endtask

    task automatic test_overrun();
        beat_t e0[$];
        beat_t e1[$];
        do_reset();
        @(negedge clk); #1;
        push_burst(0, 6, 0);
        push_burst(1, 2, 1);
        e0 = srcq[0];
        e1 = srcq[1];
        wait_obs(6, 200);
        n_cmp++; if (obs.size() < 6) begin n_fail++; $display("FAIL ovr_count: got %0d want >=6", obs.size()); end
        for (int k = 0; k < 4 && k < obs.size(); k++) begin
            n_cmp++; if (obs[k] !== e0[k]) begin n_fail++; $display("FAIL ovr_src0_beat%0d: got %h want %h", k, obs[k], e0[k]); end
        end
        for (int k = 0; k < 2 && k + 4 < obs.size(); k++) begin
            n_cmp++; if (obs[k+4] !== e1[k]) begin n_fail++; $display("FAIL ovr_src1_beat%0d: got %h want %h", k, obs[k+4], e1[k]); end
        end
        n_cmp++; if (out_err !== 1'b1) begin n_fail++; $display("FAIL ovr_err: got %b want 1", out_err); end
        n_cmp++;
        if (grant_log.size() < 2 || grant_log[0] !== 0 || grant_log[1] !== 1) begin
            n_fail++;
            $display("FAIL ovr_order: got %0d grants first=%0d want 0 then 1", grant_log.size(),
                     grant_log.size() > 0 ? grant_log[0] : -1);
        end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        @(negedge clk); #1;
        push_burst(0, 1, 1);
        push_burst(1, 4, 1);
        wait_obs(3, 100);
        n_cmp++; if (obs.size() !== 3) begin n_fail++; $display("FAIL mid_reach: got %0d beats want 3", obs.size()); end
        reset_ = 1'b0;
        #1;
        n_cmp++;
        if (out_srvalid !== 1'b0 || out_grant !== '0 || out_rdata !== '0 || out_rlast !== 1'b0 ||
            out_mrready !== '0 || out_err !== 1'b0 || out_rid !== '0) begin
            n_fail++;
            $display("FAIL mid_async: got v=%b g=%b d=%h l=%b rdy=%b e=%b want all 0",
                     out_srvalid, out_grant, out_rdata, out_rlast, out_mrready, out_err);
        end
        reset_clear();
        push_burst(1, 1, 1);
        push_burst(0, 1, 1);
        repeat (2) @(negedge clk);
        #1;
        reset_ = 1'b1;
        wait_obs(2, 100);
        n_cmp++;
        if (grant_log.size() < 1 || grant_log[0] !== 0) begin
            n_fail++;
            $display("FAIL mid_next_grant: got %0d want 0", grant_log.size() > 0 ? grant_log[0] : -1);
        end
        n_cmp++; if (obs.size() !== 2) begin n_fail++; $display("FAIL mid_after_count: got %0d want 2", obs.size()); end
    endtask

    task automatic test_random(input int bursts_max);
        do_reset();
        @(negedge clk); #1;
        gap_pct = 30; stall_pct = 30; ready_rand = 1;
        for (int s = 0; s < N; s++) begin
            int nb;
            nb = $urandom_range(bursts_max, 2);
            for (int j = 0; j < nb; j++) begin
                if (j < nb - 1 && $urandom_range(3) == 0) push_burst(s, $urandom_range(6, 5), 0);
                else push_burst(s, $urandom_range(4, 1), 1);
            end
        end
        build_model();
        wait_obs(expq.size(), 5000);
        n_cmp++; if (obs.size() !== expq.size()) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", obs.size(), expq.size()); end
        for (int k = 0; k < expq.size() && k < obs.size(); k++) begin
            n_cmp++; if (obs[k] !== expq[k]) begin n_fail++; $display("FAIL rnd_beat%0d: got %h want %h", k, obs[k], expq[k]); end
        end
        n_cmp++; if (grant_log.size() !== exp_grants.size()) begin n_fail++; $display("FAIL rnd_ngrants: got %0d want %0d", grant_log.size(), exp_grants.size()); end
        for (int k = 0; k < exp_grants.size() && k < grant_log.size(); k++) begin
            n_cmp++; if (grant_log[k] !== exp_grants[k]) begin n_fail++; $display("FAIL rnd_order%0d: got %0d want %0d", k, grant_log[k], exp_grants[k]); end
        end
        n_cmp++; if (out_err !== exp_err) begin n_fail++; $display("FAIL rnd_err: got %b want %b", out_err, exp_err); end
        n_cmp++; if (stall_viol !== 0) begin n_fail++; $display("FAIL rnd_stable: got %0d want 0", stall_viol); end
        n_cmp++; if (no_gap_cnt !== 0) begin n_fail++; $display("FAIL rnd_gap: got %0d want 0", no_gap_cnt); end
        n_cmp++; if (bad_grant !== 0) begin n_fail++; $display("FAIL rnd_onehot: got %0d want 0", bad_grant); end
        n_cmp++; if (bad_ready !== 0) begin n_fail++; $display("FAIL rnd_mrready: got %0d want 0", bad_ready); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; tag_ctr = 0;
        reset_ = 1'b0;
        hold_pending = 1'b0; prev_grant = '0; held = '0;
        in_mrvalid = '0; in_rid = '0; in_rdata = '0; in_rresp = '0;
        in_ruser = '0; in_rlast = '0; in_srready = 1'b1;
        reset_clear();
        test_reset();
        test_single_burst();
        test_alternate();
        test_backpressure();
        test_overrun();
        test_reset_midburst();
        test_random(4);
        test_random(6);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_axi_rdata_arb
`default_nettype wire
